clock_divider: RTL and testbench

CLOCK_DIVIDER -- requirements
Module: clock_divider

---
 rtl/clock_divider_if.sv | 24 ++
 rtl/clock_divider.sv | 68 ++++++
 tb/tb_clock_divider.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_divider_if.sv
// Control and status bundle for the multi-channel clock divider.
// The master drives run/load/polarity controls; the slave returns divided clocks and flags.
interface clock_divider_if #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 2
);
   logic [CHANNELS-1:0]       enable;
   logic [CHANNELS-1:0]       load;
   logic [CHANNELS*WIDTH-1:0] divisor;
   logic [CHANNELS-1:0]       invert;
   logic [CHANNELS-1:0]       out;
   logic [CHANNELS-1:0]       tick;
   logic [CHANNELS-1:0]       pending;

   modport master (
      output enable, load, divisor, invert,
      input  out, tick, pending
   );

   modport slave (
      input  enable, load, divisor, invert,
      output out, tick, pending
   );
endinterface

// File: rtl/clock_divider.sv
// Independent per-channel clock dividers with a shadowed divisor that is only
// applied on a terminal count, so ratio changes always land on a half-period boundary.
module clock_divider #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned CHANNELS    = 2,
   parameter int unsigned DEFAULT_DIV = 0
) (
   input  logic           clock,
   input  logic           reset_n,
   clock_divider_if.slave bus
);

   logic [WIDTH-1:0]    cnt   [CHANNELS];
   logic [WIDTH-1:0]    div_q [CHANNELS];
   logic [WIDTH-1:0]    shd   [CHANNELS];
   logic [CHANNELS-1:0] toggle_q;
   logic [CHANNELS-1:0] tick_q;
   logic [CHANNELS-1:0] pending_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt[i]   <= '0;
            div_q[i] <= WIDTH'(DEFAULT_DIV);
            shd[i]   <= WIDTH'(DEFAULT_DIV);
         end
         toggle_q  <= '0;
         tick_q    <= '0;
         pending_q <= '0;
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (bus.enable[i]) begin
               if (cnt[i] == div_q[i]) begin
                  cnt[i]      <= '0;
                  toggle_q[i] <= ~toggle_q[i];
                  tick_q[i]   <= 1'b1;
                  if (pending_q[i]) begin
                     div_q[i]     <= shd[i];
                     pending_q[i] <= 1'b0;
                  end
               end else begin
                  cnt[i]    <= cnt[i] + 1'b1;
                  tick_q[i] <= 1'b0;
               end
               // A load on a terminal-count edge re-arms pending, deferring it one half-period.
               if (bus.load[i]) begin
                  shd[i]       <= bus.divisor[i*WIDTH +: WIDTH];
                  pending_q[i] <= 1'b1;
               end
            end else begin
               tick_q[i] <= 1'b0;
               // Clearing cnt alongside the divisor keeps cnt <= div_q.
               if (bus.load[i]) begin
                  div_q[i]     <= bus.divisor[i*WIDTH +: WIDTH];
                  shd[i]       <= bus.divisor[i*WIDTH +: WIDTH];
                  cnt[i]       <= '0;
                  pending_q[i] <= 1'b0;
               end
            end
         end
      end
   end

   assign bus.out     = toggle_q ^ bus.invert;
   assign bus.tick    = tick_q;
   assign bus.pending = pending_q;

endmodule

// File: tb/tb_clock_divider.sv
// Scenario bench for clock_divider: per-cycle expectations are queued from the
// divider's period rules and compared on the falling edge.
module tb_clock_divider;
   localparam int unsigned WIDTH    = 8;
   localparam int unsigned CHANNELS = 2;

   typedef struct packed {
      logic [1:0] out;
      logic [1:0] tick;
      logic [1:0] pending;
   } exp_t;

   logic clock = 1'b0;
   logic reset_n;
   exp_t sb[$];
   exp_t e;
   exp_t got;
   int tests = 0;
   int fails = 0;

   clock_divider_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

   clock_divider #(
      .WIDTH(WIDTH),
      .CHANNELS(CHANNELS),
      .DEFAULT_DIV(0)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus(bus)
   );

   always #5 clock = ~clock;

   task automatic test_reset();
      reset_n     = 1'b0;
      bus.enable  = '0;
      bus.load    = '0;
      bus.divisor = '0;
      bus.invert  = 2'b10;
      repeat (2) @(negedge clock);
      tests++;
      if (bus.out !== 2'b10) begin
         fails++;
         $display("FAIL reset_out: got %b want 10", bus.out);
      end
      tests++;
      if (bus.tick !== 2'b00) begin
         fails++;
         $display("FAIL reset_tick: got %b want 00", bus.tick);
      end
      tests++;
      if (bus.pending !== 2'b00) begin
         fails++;
         $display("FAIL reset_pending: got %b want 00", bus.pending);
      end
      bus.invert = 2'b00;
      #1;
      tests++;
      if (bus.out !== 2'b00) begin
         fails++;
         $display("FAIL reset_invert: got %b want 00", bus.out);
      end
      reset_n    = 1'b1;
      bus.enable = 2'b01;
   endtask

   task automatic test_div0();
      for (int k = 1; k <= 6; k++)
         sb.push_back(exp_t'({1'b0, k[0], 2'b01, 2'b00}));
      for (int k = 1; k <= 6; k++) begin
         @(negedge clock);
         e = sb.pop_front();
         got = exp_t'({bus.out, bus.tick, bus.pending});
         tests++;
         if (got !== e) begin
            fails++;
            $display("FAIL div0 cyc %0d: got out=%b tick=%b pend=%b want out=%b tick=%b pend=%b",
                     k, got.out, got.tick, got.pending, e.out, e.tick, e.pending);
         end
      end
   endtask

   task automatic test_load();
      logic o, t;
      bus.load    = 2'b01;
      bus.divisor = {8'd0, 8'd3};
      sb.push_back(exp_t'({2'b01, 2'b01, 2'b01}));
      for (int j = 2; j <= 10; j++) begin
         t = ((j - 2) % 4 == 0);
         o = (((j - 2) / 4) % 2 == 1);
         sb.push_back(exp_t'({1'b0, o, 1'b0, t, 2'b00}));
      end
      for (int j = 1; j <= 10; j++) begin
         @(negedge clock);
         e = sb.pop_front();
         got = exp_t'({bus.out, bus.tick, bus.pending});
         tests++;
         if (got !== e) begin
            fails++;
            $display("FAIL load cyc %0d: got out=%b tick=%b pend=%b want out=%b tick=%b pend=%b",
                     j, got.out, got.tick, got.pending, e.out, e.tick, e.pending);
         end
         if (j == 1) bus.load = 2'b00;
      end
   endtask

   task automatic test_invert();
      logic tog, inv;
      for (int m = 1; m <= 12; m++) begin
         tog = ((m / 4) % 2 == 1);
         inv = (m >= 3);
         sb.push_back(exp_t'({1'b0, tog ^ inv, 1'b0, (m % 4 == 0), 2'b00}));
      end
      for (int m = 1; m <= 12; m++) begin
         @(negedge clock);
         e = sb.pop_front();
         got = exp_t'({bus.out, bus.tick, bus.pending});
         tests++;
         if (got !== e) begin
            fails++;
            $display("FAIL invert cyc %0d: got out=%b tick=%b pend=%b want out=%b tick=%b pend=%b",
                     m, got.out, got.tick, got.pending, e.out, e.tick, e.pending);
         end
         if (m == 2) begin
            bus.invert = 2'b01;
            #1;
            tests++;
            if (bus.out !== 2'b01) begin
               fails++;
               $display("FAIL invert_immediate: got %b want 01", bus.out);
            end
         end
      end
      bus.invert = 2'b00;
   endtask

   task automatic test_coincident();
      logic tog, t;
      tog = 1'b1;
      for (int m = 1; m <= 17; m++) begin
         t = (m == 4) || (m == 8) || (m >= 11 && (m - 11) % 3 == 0);
         if (t) tog = ~tog;
         sb.push_back(exp_t'({1'b0, tog, 1'b0, t, 1'b0, (m >= 4 && m <= 7)}));
      end
      for (int m = 1; m <= 17; m++) begin
         @(negedge clock);
         e = sb.pop_front();
         got = exp_t'({bus.out, bus.tick, bus.pending});
         tests++;
         if (got !== e) begin
            fails++;
            $display("FAIL coincident cyc %0d: got out=%b tick=%b pend=%b want out=%b tick=%b pend=%b",
                     m, got.out, got.tick, got.pending, e.out, e.tick, e.pending);
         end
         case (m)
            3: begin bus.load = 2'b01; bus.divisor = {8'd0, 8'd5}; end
            5: begin bus.load = 2'b01; bus.divisor = {8'd0, 8'd2}; end
            default: bus.load = 2'b00;
         endcase
      end
   endtask

   task automatic test_disabled_load();
      logic tog, t, en;
      int c;
      bus.enable  = 2'b00;
      bus.load    = 2'b10;
      bus.divisor = {8'd255, 8'd0};
      @(negedge clock);
      tests++;
      if ({bus.out, bus.tick, bus.pending} !== 6'b0) begin
         fails++;
         $display("FAIL disabled_load: got out=%b tick=%b pend=%b want all 0",
                  bus.out, bus.tick, bus.pending);
      end
      bus.load   = 2'b00;
      bus.enable = 2'b10;
      tog = 1'b0;
      for (int k = 1; k <= 530; k++) begin
         en = !(k >= 301 && k <= 310);
         c  = (k <= 300) ? k : k - 10;
         t  = en && (c % 256 == 0);
         if (t) tog = ~tog;
         sb.push_back(exp_t'({tog, 1'b0, t, 1'b0, 2'b00}));
      end
      for (int k = 1; k <= 530; k++) begin
         @(negedge clock);
         e = sb.pop_front();
         got = exp_t'({bus.out, bus.tick, bus.pending});
         tests++;
         if (got !== e) begin
            fails++;
            $display("FAIL div255 cyc %0d: got out=%b tick=%b pend=%b want out=%b tick=%b pend=%b",
                     k, got.out, got.tick, got.pending, e.out, e.tick, e.pending);
         end
         if (k == 300) bus.enable = 2'b00;
         if (k == 310) bus.enable = 2'b10;
      end
   endtask

   task automatic test_reset_mid();
      bus.enable = 2'b11;
      sb.push_back(exp_t'({2'b00, 2'b00, 2'b00}));
      sb.push_back(exp_t'({2'b00, 2'b00, 2'b00}));
      sb.push_back(exp_t'({2'b01, 2'b01, 2'b00}));
      sb.push_back(exp_t'({2'b01, 2'b00, 2'b01}));
      for (int r = 1; r <= 4; r++) begin
         @(negedge clock);
         e = sb.pop_front();
         got = exp_t'({bus.out, bus.tick, bus.pending});
         tests++;
         if (got !== e) begin
            fails++;
            $display("FAIL pre_reset cyc %0d: got out=%b tick=%b pend=%b want out=%b tick=%b pend=%b",
                     r, got.out, got.tick, got.pending, e.out, e.tick, e.pending);
         end
         if (r == 3) begin
            bus.load    = 2'b01;
            bus.divisor = {8'd0, 8'd1};
         end
      end
      bus.load = 2'b00;
      reset_n  = 1'b0;
      #1;
      tests++;
      if (bus.out !== 2'b00) begin
         fails++;
         $display("FAIL midreset_out: got %b want 00", bus.out);
      end
      tests++;
      if (bus.tick !== 2'b00) begin
         fails++;
         $display("FAIL midreset_tick: got %b want 00", bus.tick);
      end
      tests++;
      if (bus.pending !== 2'b00) begin
         fails++;
         $display("FAIL midreset_pending: got %b want 00", bus.pending);
      end
      @(negedge clock);
      reset_n = 1'b1;
      sb.push_back(exp_t'({2'b11, 2'b11, 2'b00}));
      sb.push_back(exp_t'({2'b00, 2'b11, 2'b00}));
      sb.push_back(exp_t'({2'b11, 2'b11, 2'b00}));
      for (int r = 1; r <= 3; r++) begin
         @(negedge clock);
         e = sb.pop_front();
         got = exp_t'({bus.out, bus.tick, bus.pending});
         tests++;
         if (got !== e) begin
            fails++;
            $display("FAIL post_reset cyc %0d: got out=%b tick=%b pend=%b want out=%b tick=%b pend=%b",
                     r, got.out, got.tick, got.pending, e.out, e.tick, e.pending);
         end
      end
   endtask

   initial begin
      test_reset();
      test_div0();
      test_load();
      test_invert();
      test_coincident();
      test_disabled_load();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
